// File: rtl/spi_a2d_resp.sv
// SPI responder modelling the converter side of an 8-channel A2D link: one 16-bit
// command frame selects a channel, whose 12-bit sample is returned in the next frame.
// Optional command-format check is enabled by defining A2D_RESP_CMD_CHK_EN.
module spi_a2d_resp #(
    parameter int NUM_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] chan_data,
    output logic [2:0]  cmd_ch,
    output logic        xfer_done,
    output logic        frame_err,
    output logic        cmd_err
);

    typedef enum logic [1:0] {
        DISARMED,
        IDLE,
        SHIFT
    } state_t;

    localparam logic [4:0] FULL_CNT = 5'(NUM_BITS);

    state_t                state, next_state;
    logic [2:0]            ss_q, sclk_q;
    logic [1:0]            mosi_q;
    logic [NUM_BITS-1:0]   tx_shft, rx_shft;
    logic [4:0]            bit_cnt;
    logic [7:0][11:0]      samples;

    logic ss_sync, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;
    logic frame_end, frame_full, cmd_ok, accept, short_frame, bad_cmd;

    assign samples = chan_data;

    // Synchronizers reset low so that a slave select still held low through reset
    // keeps the block DISARMED until the master really releases it.
    // NOTE: all sequential state uses non-blocking assignments and a synchronous reset
    // sampled on the clock edge; combinational blocks use blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], SS_n};
            sclk_q <= {sclk_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign ss_sync   = ss_q[1];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_sync = mosi_q[1];

    always_ff @(posedge clk) begin
        if (rst) state <= DISARMED;
        else     state <= next_state;
    end

    // NOTE: next_state is given a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            DISARMED: if (ss_sync) next_state = IDLE;
            IDLE:     if (ss_fall) next_state = SHIFT;
            SHIFT:    if (ss_rise) next_state = IDLE;
            default:  next_state = DISARMED;
        endcase
    end

`ifdef A2D_RESP_CMD_CHK_EN
    assign cmd_ok = (rx_shft[15:14] == 2'b00) && (rx_shft[10:0] == 11'd0);
`else
    logic unused_cmd_bits;
    assign cmd_ok          = 1'b1;
    assign unused_cmd_bits = ^{rx_shft[15:14], rx_shft[10:0]};
`endif

    always_comb begin
        MISO        = 1'b0;
        frame_end   = 1'b0;
        frame_full  = (bit_cnt == FULL_CNT);
        accept      = 1'b0;
        short_frame = 1'b0;
        bad_cmd     = 1'b0;
        if (state == SHIFT) begin
            MISO        = tx_shft[NUM_BITS-1];
            frame_end   = ss_rise;
            accept      = frame_end & frame_full & cmd_ok;
            bad_cmd     = frame_end & frame_full & ~cmd_ok;
            short_frame = frame_end & ~frame_full;
        end
    end

    // cmd_ch is registered alongside the pulses, so a frame starting right after
    // ss_rise already selects the freshly decoded channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shft   <= '0;
            rx_shft   <= '0;
            bit_cnt   <= '0;
            cmd_ch    <= '0;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            xfer_done <= accept;
            frame_err <= short_frame;
            if (accept) cmd_ch <= rx_shft[13:11];
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_shft <= {4'h0, samples[cmd_ch]};
                        rx_shft <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!ss_rise) begin
                        if (sclk_rise) begin
                            rx_shft <= {rx_shft[NUM_BITS-2:0], mosi_sync};
                            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_fall) tx_shft <= {tx_shft[NUM_BITS-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef A2D_RESP_CMD_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) cmd_err <= 1'b0;
        else     cmd_err <= bad_cmd;
    end
`else
    logic unused_bad_cmd;
    assign unused_bad_cmd = bad_cmd;
    assign cmd_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_a2d_resp.sv
// Directed bench for spi_a2d_resp: drives SPI mode-0 frames and compares returned
// words, strobe counts and the latched channel against hand-computed values.
module tb_spi_a2d_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] chan_data;
    logic [2:0]  cmd_ch;
    logic        xfer_done;
    logic        frame_err;
    logic        cmd_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_ferr  = 0;
    int n_cerr  = 0;

    spi_a2d_resp #(.NUM_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .chan_data (chan_data),
        .cmd_ch    (cmd_ch),
        .xfer_done (xfer_done),
        .frame_err (frame_err),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Counting high cycles (not edges) also catches a strobe that lasts too long.
    always @(negedge clk) begin
        if (xfer_done) n_done++;
        if (frame_err) n_ferr++;
        if (cmd_err)   n_cerr++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [11:0] v);
        chan_data[ch*12 +: 12] = v;
    endtask

    // Mode-0 master: 8 clk per SCLK phase, MISO sampled at each SCLK rise.
    task automatic run_frame(input logic [15:0] cmd, input int nbits, input int gap,
                             output logic [15:0] rd);
        rd = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = cmd[15-i];
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            rd   = {rd[14:0], MISO};
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    int d0, f0, c0;
    task automatic mark();
        d0 = n_done; f0 = n_ferr; c0 = n_cerr;
    endtask

    task automatic check_pulses(input string tag, input int d, input int f, input int c);
        check({tag, "_done"}, n_done - d0, d);
        check({tag, "_ferr"}, n_ferr - f0, f);
        check({tag, "_cerr"}, n_cerr - c0, c);
    endtask

    logic [15:0] rd, rd_b;

    initial begin
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; chan_data = '0;
        set_ch(0, 12'hABC);
        repeat (4) @(negedge clk);
        check("rst_miso", MISO, 1'b0);
        check("rst_cmd_ch", cmd_ch, 3'd0);
        check("rst_pulses", {xfer_done, frame_err, cmd_err}, 3'b000);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Default channel after reset
        mark();
        run_frame(16'h0000, 16, 10, rd);
        check("t1_miso", rd, 16'h0ABC);
        check_pulses("t1", 1, 0, 0);
        check("t1_cmd_ch", cmd_ch, 3'd0);

        // One-frame response pipeline
        set_ch(5, 12'h123);
        mark();
        run_frame(16'h2800, 16, 10, rd);
        check("t2a_miso", rd, 16'h0ABC);
        check("t2a_cmd_ch", cmd_ch, 3'd5);
        run_frame(16'h0000, 16, 10, rd);
        check("t2b_miso", rd, 16'h0123);
        check("t2b_cmd_ch", cmd_ch, 3'd0);
        check_pulses("t2", 2, 0, 0);

        // Short frame leaves cmd_ch alone
        run_frame(16'h2800, 16, 10, rd);
        check("t3a_cmd_ch", cmd_ch, 3'd5);
        mark();
        run_frame(16'h1000, 10, 10, rd);
        check_pulses("t3_short", 0, 1, 0);
        check("t3_short_cmd_ch", cmd_ch, 3'd5);
        mark();
        run_frame(16'h0000, 16, 10, rd);
        check("t3c_miso", rd, 16'h0123);
        check("t3c_cmd_ch", cmd_ch, 3'd0);
        check_pulses("t3c", 1, 0, 0);

        // Reset between bits 6 and 7 with SS_n held low
        mark();
        fork
            run_frame(16'h2800, 16, 10, rd);
            begin
                repeat (104) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        check("t4_miso", rd, 16'h0800);
        check_pulses("t4", 0, 0, 0);
        check("t4_cmd_ch", cmd_ch, 3'd0);
        mark();
        run_frame(16'h2800, 16, 10, rd);
        check("t4b_miso", rd, 16'h0ABC);
        check("t4b_cmd_ch", cmd_ch, 3'd5);
        check_pulses("t4b", 1, 0, 0);

        // Malformed command
        run_frame(16'h0000, 16, 10, rd);
        check("t5a_miso", rd, 16'h0123);
        check("t5a_cmd_ch", cmd_ch, 3'd0);
        mark();
        run_frame(16'hE801, 16, 10, rd);
        check("t5_miso", rd, 16'h0ABC);
`ifdef A2D_RESP_CMD_CHK_EN
        check_pulses("t5", 0, 0, 1);
        check("t5_cmd_ch", cmd_ch, 3'd0);
`else
        check_pulses("t5", 1, 0, 0);
        check("t5_cmd_ch", cmd_ch, 3'd5);
`endif

        // Back-to-back frames, one clk of SS_n high, sample changing mid-frame
        set_ch(2, 12'h456);
        mark();
        run_frame(16'h1000, 16, 0, rd);
`ifdef A2D_RESP_CMD_CHK_EN
        check("t6a_miso", rd, 16'h0ABC);
`else
        check("t6a_miso", rd, 16'h0123);
`endif
        fork
            run_frame(16'h0000, 16, 10, rd_b);
            begin
                repeat (60) @(negedge clk);
                set_ch(2, 12'hFFF);
            end
        join
        check("t6b_miso", rd_b, 16'h0456);
        check_pulses("t6", 2, 0, 0);
        check("t6b_cmd_ch", cmd_ch, 3'd0);
        run_frame(16'h1000, 16, 10, rd);
        check("t6c_miso", rd, 16'h0ABC);
        run_frame(16'h0000, 16, 10, rd);
        check("t6d_miso", rd, 16'h0FFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
